// File: rtl/hot_tracker_mig_sched.sv
// Epoch scheduler for two hot-page trackers: issues QUERY_MIG, captures
// both top-5 snapshots and streams eligible hot addresses downstream.
module hot_tracker_mig_sched #(
    parameter int ADDR_SIZE   = 28,
    parameter int CNT_SIZE    = 13,
    parameter int CMD_WIDTH   = 4,
    parameter int TOP_K       = 5,
    parameter int MIG_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_enable,
    input  logic [31:0]               cfg_epoch_cycles,
    input  logic [2:0]                cfg_num_mig,
    input  logic [CNT_SIZE-1:0]       cfg_cnt_thresh,
    input  logic                      sw_trigger,
    output logic                      t0_query_en,
    output logic [CMD_WIDTH-1:0]      t0_query_cmd,
    output logic                      t1_query_en,
    output logic [CMD_WIDTH-1:0]      t1_query_cmd,
    input  logic                      t0_query_ready,
    input  logic                      t1_query_ready,
    output logic                      both_query_ready,
    input  logic                      t0_mig_en,
    input  logic                      t1_mig_en,
    input  logic [5*ADDR_SIZE-1:0]    t0_top_addr,
    input  logic [5*CNT_SIZE-1:0]     t0_top_cnt,
    input  logic [5*ADDR_SIZE-1:0]    t1_top_addr,
    input  logic [5*CNT_SIZE-1:0]     t1_top_cnt,
    output logic [2:0]                num_mig,
    output logic                      mig_addr_valid,
    output logic [ADDR_SIZE-1:0]      mig_addr,
    output logic                      mig_src,
    input  logic                      mig_addr_ready,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [15:0]               mig_emitted_cnt
);

    localparam int TW = $clog2(MIG_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MIG, DRAIN} state_t;

    state_t state, state_nx;

    logic [31:0]          epoch_cnt;
    logic                 pending;
    logic                 cap0, cap1;
    logic [TW-1:0]        tmo_cnt;
    logic [3:0]           slot_idx;
    logic [ADDR_SIZE-1:0] snap_addr [2][TOP_K];
    logic [CNT_SIZE-1:0]  snap_cnt  [2][TOP_K];

    logic                 epoch_hit, start, capturing, all_cap, tmo_hit;
    logic [2:0]           clamp;
    logic [3:0]           total, nm_ext, sel_slot;
    logic                 sel_src, eligible, handshake, drain_done;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [CNT_SIZE-1:0]  sel_cnt;

    assign both_query_ready = t0_query_ready & t1_query_ready;

    assign epoch_hit = cfg_enable && (cfg_epoch_cycles != 32'd0) &&
                       (epoch_cnt == cfg_epoch_cycles - 32'd1);
    assign start     = epoch_hit || sw_trigger || pending;
    assign capturing = (state == ISSUE) || (state == WAIT_MIG);
    // A mig_en pulse this cycle counts toward completion so DRAIN starts a cycle early.
    assign all_cap   = (cap0 | t0_mig_en) & (cap1 | t1_mig_en);
    assign tmo_hit   = (tmo_cnt == TW'(MIG_TIMEOUT - 1));
    assign clamp     = (cfg_num_mig > 3'd5) ? 3'd5 : cfg_num_mig;

    assign nm_ext     = {1'b0, num_mig};
    assign total      = {num_mig, 1'b0};
    assign sel_src    = (slot_idx >= nm_ext);
    assign sel_slot   = sel_src ? (slot_idx - nm_ext) : slot_idx;
    assign handshake  = mig_addr_valid && mig_addr_ready;
    assign drain_done = !mig_addr_valid && (slot_idx >= total);

    always_comb begin
        sel_addr = '0;
        sel_cnt  = '0;
        if (sel_slot < 4'(TOP_K)) begin
            sel_addr = snap_addr[sel_src][sel_slot[2:0]];
            sel_cnt  = snap_cnt[sel_src][sel_slot[2:0]];
        end
    end

    assign eligible = (sel_cnt >= cfg_cnt_thresh) && (sel_cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (start) state_nx = ISSUE;
            ISSUE:    if (both_query_ready) state_nx = WAIT_MIG;
            WAIT_MIG: begin
                if (all_cap)      state_nx = DRAIN;
                else if (tmo_hit) state_nx = IDLE;
            end
            DRAIN:    if (drain_done) state_nx = IDLE;
        endcase
    end

    always_comb begin
        t0_query_en  = (state == ISSUE);
        t1_query_en  = (state == ISSUE);
        t0_query_cmd = t0_query_en ? CMD_WIDTH'(1) : '0;
        t1_query_cmd = t1_query_en ? CMD_WIDTH'(1) : '0;
        busy         = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epoch_cnt       <= '0;
            pending         <= 1'b0;
            num_mig         <= '0;
            cap0            <= 1'b0;
            cap1            <= 1'b0;
            tmo_cnt         <= '0;
            slot_idx        <= '0;
            mig_addr_valid  <= 1'b0;
            mig_addr        <= '0;
            mig_src         <= 1'b0;
            timeout_err     <= 1'b0;
            mig_emitted_cnt <= '0;
            for (int t = 0; t < 2; t++) begin
                for (int k = 0; k < TOP_K; k++) begin
                    snap_addr[t][k] <= '0;
                    snap_cnt[t][k]  <= '0;
                end
            end
        end else begin
            if (sw_trigger && state != IDLE) pending <= 1'b1;
            if (capturing && t0_mig_en) begin
                cap0 <= 1'b1;
                for (int k = 0; k < TOP_K; k++) begin
                    snap_addr[0][k] <= t0_top_addr[k*ADDR_SIZE +: ADDR_SIZE];
                    snap_cnt[0][k]  <= t0_top_cnt[k*CNT_SIZE +: CNT_SIZE];
                end
            end
            if (capturing && t1_mig_en) begin
                cap1 <= 1'b1;
                for (int k = 0; k < TOP_K; k++) begin
                    snap_addr[1][k] <= t1_top_addr[k*ADDR_SIZE +: ADDR_SIZE];
                    snap_cnt[1][k]  <= t1_top_cnt[k*CNT_SIZE +: CNT_SIZE];
                end
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        epoch_cnt <= '0;
                        pending   <= 1'b0;
                        num_mig   <= clamp;
                    end else if (cfg_enable && cfg_epoch_cycles != 32'd0) begin
                        epoch_cnt <= epoch_cnt + 32'd1;
                    end
                end
                ISSUE: tmo_cnt <= '0;
                WAIT_MIG: begin
                    if (all_cap) begin
                        slot_idx <= '0;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        cap0        <= 1'b0;
                        cap1        <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        mig_addr_valid <= 1'b0;
                        slot_idx       <= slot_idx + 4'd1;
                        if (mig_emitted_cnt != 16'hFFFF)
                            mig_emitted_cnt <= mig_emitted_cnt + 16'd1;
                    end else if (!mig_addr_valid) begin
                        if (drain_done) begin
                            cap0 <= 1'b0;
                            cap1 <= 1'b0;
                        end else if (eligible) begin
                            mig_addr_valid <= 1'b1;
                            mig_addr       <= sel_addr;
                            mig_src        <= sel_src;
                        end else begin
                            slot_idx <= slot_idx + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hot_tracker_mig_sched.sv
// Directed bench for hot_tracker_mig_sched: epochs, skew, threshold,
// clamp, timeout, coalesced trigger and asynchronous reset.
module tb_hot_tracker_mig_sched;

    localparam int AS = 28;
    localparam int CS = 13;
    localparam logic [AS-1:0] A0 = 28'h100_0000;
    localparam logic [AS-1:0] A1 = 28'h200_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_enable;
    logic [31:0]   cfg_epoch_cycles;
    logic [2:0]    cfg_num_mig;
    logic [CS-1:0] cfg_cnt_thresh;
    logic          sw_trigger;
    logic          t0_query_en, t1_query_en;
    logic [3:0]    t0_query_cmd, t1_query_cmd;
    logic          t0_query_ready, t1_query_ready, both_query_ready;
    logic          t0_mig_en, t1_mig_en;
    logic [5*AS-1:0] t0_top_addr, t1_top_addr;
    logic [5*CS-1:0] t0_top_cnt, t1_top_cnt;
    logic [2:0]    num_mig;
    logic          mig_addr_valid;
    logic [AS-1:0] mig_addr;
    logic          mig_src;
    logic          mig_addr_ready;
    logic          busy, timeout_err;
    logic [15:0]   mig_emitted_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int stable_bad = 0;
    logic [AS-1:0] got_addr[$];
    logic          got_src[$];

    always #5 clk = ~clk;

    hot_tracker_mig_sched dut (
        .clk(clk), .reset(reset),
        .cfg_enable(cfg_enable), .cfg_epoch_cycles(cfg_epoch_cycles),
        .cfg_num_mig(cfg_num_mig), .cfg_cnt_thresh(cfg_cnt_thresh),
        .sw_trigger(sw_trigger),
        .t0_query_en(t0_query_en), .t0_query_cmd(t0_query_cmd),
        .t1_query_en(t1_query_en), .t1_query_cmd(t1_query_cmd),
        .t0_query_ready(t0_query_ready), .t1_query_ready(t1_query_ready),
        .both_query_ready(both_query_ready),
        .t0_mig_en(t0_mig_en), .t1_mig_en(t1_mig_en),
        .t0_top_addr(t0_top_addr), .t0_top_cnt(t0_top_cnt),
        .t1_top_addr(t1_top_addr), .t1_top_cnt(t1_top_cnt),
        .num_mig(num_mig), .mig_addr_valid(mig_addr_valid),
        .mig_addr(mig_addr), .mig_src(mig_src),
        .mig_addr_ready(mig_addr_ready), .busy(busy),
        .timeout_err(timeout_err), .mig_emitted_cnt(mig_emitted_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cnts(input logic [CS-1:0] c0, c1, c2, c3, c4);
        t0_top_cnt = {c4, c3, c2, c1, c0};
        t1_top_cnt = {c4, c3, c2, c1, c0};
    endtask

    // Call from IDLE; returns in the first ISSUE cycle.
    task automatic trigger();
        sw_trigger = 1'b1;
        tick();
        sw_trigger = 1'b0;
    endtask

    // Call in ISSUE; returns in the first DRAIN cycle.
    task automatic serve();
        t0_query_ready = 1'b1;
        t1_query_ready = 1'b1;
        tick();
        t0_query_ready = 1'b0;
        t1_query_ready = 1'b0;
        t0_mig_en = 1'b1;
        t1_mig_en = 1'b1;
        tick();
        t0_mig_en = 1'b0;
        t1_mig_en = 1'b0;
    endtask

    task automatic drain(input int stall);
        int guard;
        logic [AS-1:0] a;
        got_addr.delete();
        got_src.delete();
        guard = 0;
        while (busy && guard < 2000) begin
            if (mig_addr_valid) begin
                a = mig_addr;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    if (mig_addr !== a || mig_addr_valid !== 1'b1)
                        stable_bad++;
                end
                mig_addr_ready = 1'b1;
                got_addr.push_back(mig_addr);
                got_src.push_back(mig_src);
                tick();
                mig_addr_ready = 1'b0;
            end else begin
                tick();
            end
            guard++;
        end
        chk("drain_bound", 64'(guard < 2000), 64'd1);
    endtask

    task automatic cmp_beats(input string tag, input logic [4:0] mask);
        logic [AS-1:0] ea[$];
        logic          es[$];
        for (int t = 0; t < 2; t++)
            for (int s = 0; s < 5; s++)
                if (mask[s]) begin
                    ea.push_back((t == 0 ? A0 : A1) + AS'(s));
                    es.push_back(t[0]);
                end
        chk({tag, "_n"}, 64'(got_addr.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < got_addr.size(); i++)
            chk({tag, "_beat"}, {35'd0, got_src[i], got_addr[i]},
                {35'd0, es[i], ea[i]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        cfg_enable = 1'b0;
        cfg_epoch_cycles = 32'd0;
        cfg_num_mig = 3'd3;
        cfg_cnt_thresh = 13'd1;
        sw_trigger = 1'b0;
        t0_query_ready = 1'b0;
        t1_query_ready = 1'b0;
        t0_mig_en = 1'b0;
        t1_mig_en = 1'b0;
        mig_addr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            t0_top_addr[k*AS +: AS] = A0 + AS'(k);
            t1_top_addr[k*AS +: AS] = A1 + AS'(k);
        end
        set_cnts(13'd5, 13'd6, 13'd7, 13'd8, 13'd9);

        tick(); tick(); tick();
        chk("rst_query_en", 64'(t0_query_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(mig_addr_valid), 64'd0);
        chk("rst_num_mig", 64'(num_mig), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_emitted", 64'(mig_emitted_cnt), 64'd0);
        t0_query_ready = 1'b1;
        t1_query_ready = 1'b1;
        #1;
        chk("rst_bqr_comb", 64'(both_query_ready), 64'd1);
        t0_query_ready = 1'b0;
        t1_query_ready = 1'b0;

        // Periodic epoch of 100 cycles
        tick();
        reset = 1'b0;
        cfg_enable = 1'b1;
        cfg_epoch_cycles = 32'd100;
        for (int i = 1; i < 100; i++) tick();
        chk("per_before", 64'(t0_query_en), 64'd0);
        tick();
        chk("per_query_en", {t1_query_en, t0_query_en}, 64'd3);
        chk("per_cmd", {t1_query_cmd, t0_query_cmd}, 64'h11);
        chk("per_num_mig", 64'(num_mig), 64'd3);
        cfg_enable = 1'b0;
        serve();
        drain(0);
        cmp_beats("per", 5'b00111);
        chk("per_emitted", 64'(mig_emitted_cnt), 64'd6);

        // Skewed readiness
        trigger();
        for (int c = 1; c <= 8; c++) begin
            t0_query_ready = (c >= 2 && c <= 7);
            t1_query_ready = (c == 7);
            #1;
            chk("skew_bqr", 64'(both_query_ready), 64'(c == 7));
            chk("skew_qen", 64'(t0_query_en), 64'(c <= 7));
            tick();
        end
        t0_query_ready = 1'b0;
        t1_query_ready = 1'b0;
        t0_mig_en = 1'b1;
        tick();
        t0_mig_en = 1'b0;
        tick(); tick();
        t1_mig_en = 1'b1;
        tick();
        t1_mig_en = 1'b0;
        drain(0);
        cmp_beats("skew", 5'b00111);

        // Threshold and backpressure; snapshots arrive while still in ISSUE
        set_cnts(13'd9, 13'd4, 13'd0, 13'd12, 13'd3);
        cfg_cnt_thresh = 13'd4;
        cfg_num_mig = 3'd5;
        trigger();
        t0_query_ready = 1'b1;
        t1_query_ready = 1'b1;
        t0_mig_en = 1'b1;
        t1_mig_en = 1'b1;
        tick();
        t0_query_ready = 1'b0;
        t1_query_ready = 1'b0;
        t0_mig_en = 1'b0;
        t1_mig_en = 1'b0;
        stable_bad = 0;
        drain(5);
        cmp_beats("thr", 5'b01011);
        chk("thr_stable", 64'(stable_bad), 64'd0);
        chk("thr_emitted", 64'(mig_emitted_cnt), 64'd18);

        // Clamp to 5
        cfg_num_mig = 3'd7;
        trigger();
        chk("clamp_num_mig", 64'(num_mig), 64'd5);
        serve();
        drain(0);
        cmp_beats("clamp", 5'b01011);

        // Zero slots
        cfg_num_mig = 3'd0;
        trigger();
        chk("zero_query_en", 64'(t0_query_en), 64'd1);
        chk("zero_num_mig", 64'(num_mig), 64'd0);
        serve();
        drain(0);
        chk("zero_beats", 64'(got_addr.size()), 64'd0);
        chk("zero_emitted", 64'(mig_emitted_cnt), 64'd24);

        // Timeout: tracker 1 never delivers
        cfg_num_mig = 3'd3;
        trigger();
        t0_query_ready = 1'b1;
        t1_query_ready = 1'b1;
        tick();
        t0_query_ready = 1'b0;
        t1_query_ready = 1'b0;
        chk("tmo_err_early", 64'(timeout_err), 64'd0);
        t0_mig_en = 1'b1;
        n = 0;
        stable_bad = 0;
        while (busy && n < 200) begin
            if (mig_addr_valid) stable_bad++;
            n++;
            tick();
            t0_mig_en = 1'b0;
        end
        chk("tmo_wait_cycles", 64'(n), 64'd64);
        chk("tmo_err", 64'(timeout_err), 64'd1);
        chk("tmo_busy", 64'(busy), 64'd0);
        chk("tmo_no_beats", 64'(stable_bad), 64'd0);
        chk("tmo_emitted", 64'(mig_emitted_cnt), 64'd24);

        // Trigger during DRAIN, then reset inside the follow-up ISSUE
        trigger();
        serve();
        n = 0;
        while (!mig_addr_valid && n < 50) begin
            tick();
            n++;
        end
        chk("trg_first_valid", 64'(mig_addr_valid), 64'd1);
        sw_trigger = 1'b1;
        tick();
        sw_trigger = 1'b0;
        drain(0);
        cmp_beats("trg", 5'b00011);
        chk("trg_idle_gap", 64'(busy), 64'd0);
        tick();
        chk("trg_second_issue", 64'(t0_query_en), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_query_en", {t1_query_en, t0_query_en}, 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_valid", 64'(mig_addr_valid), 64'd0);
        chk("arst_num_mig", 64'(num_mig), 64'd0);
        chk("arst_timeout", 64'(timeout_err), 64'd0);
        chk("arst_emitted", 64'(mig_emitted_cnt), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
